vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick divider, H/V porch-sync FSMs, prefetch address and latency-aligned DAC outputs
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CLK_DIV    = 2,
  parameter int COLOR_W    = 10,
  parameter int RD_LAT     = 1
) (
  input  logic                 iClk_50,
  input  logic                 nRst,
  input  logic                 iEn,
  input  logic [3*COLOR_W-1:0] iVGA_colorData,
  output logic [31:0]          oVGA_colorAddress,
  output logic [COLOR_W-1:0]   oVGA_R,
  output logic [COLOR_W-1:0]   oVGA_G,
  output logic [COLOR_W-1:0]   oVGA_B,
  output logic                 oVGA_Clk,
  output logic                 oVGA_Blank,
  output logic                 oVGA_HSync,
  output logic                 oVGA_VSync,
  output logic                 oVGA_Sync,
  output logic                 oLineStart,
  output logic                 oFrameStart
);
  typedef enum logic [1:0] {AV, FP, SP, BP} ph_t;
  localparam int DW = $clog2(CLK_DIV);
  logic clr, tick, h_last, v_last, eol, act;
  logic [DW-1:0] div, div_nx;
  ph_t h_st, h_nx, v_st, v_nx;
  logic [11:0] hc, hc_nx, vc, vc_nx, h_len, v_len;
  logic [2:0] raw, tap;
  assign clr = !nRst || !iEn;
  assign tick = div == DW'(CLK_DIV - 1);
  assign oVGA_Sync = 1'b0;
  always_comb begin
    h_len = h_st == AV ? 12'(H_ACTIVE) : h_st == FP ? 12'(H_FP) : h_st == SP ? 12'(H_SYNC) : 12'(H_BP);
    v_len = v_st == AV ? 12'(V_ACTIVE) : v_st == FP ? 12'(V_FP) : v_st == SP ? 12'(V_SYNC) : 12'(V_BP);
    h_last = hc == h_len - 12'd1;
    v_last = vc == v_len - 12'd1;
    eol = tick && h_st == BP && h_last;
    act = h_st == AV && v_st == AV;
    raw = {act, h_st == SP, v_st == SP};
    div_nx = tick ? '0 : div + DW'(1);
    h_nx = tick && h_last ? ph_t'(h_st + 2'd1) : h_st;
    hc_nx = !tick ? hc : h_last ? 12'd0 : hc + 12'd1;
    v_nx = eol && v_last ? ph_t'(v_st + 2'd1) : v_st;
    vc_nx = !eol ? vc : v_last ? 12'd0 : vc + 12'd1;
  end
  always_ff @(posedge iClk_50) begin
    if (clr) begin
      div <= '0;
      h_st <= AV;
      v_st <= AV;
      hc <= 12'd0;
      vc <= 12'd0;
    end else begin
      div <= div_nx;
      h_st <= h_nx;
      v_st <= v_nx;
      hc <= hc_nx;
      vc <= vc_nx;
    end
  end
  if (RD_LAT == 0) begin : g_nolat
    assign tap = raw;
  end else begin : g_lat
    logic [2:0] dl [RD_LAT];
    always_ff @(posedge iClk_50) begin
      if (clr) begin
        for (int i = 0; i < RD_LAT; i++) dl[i] <= 3'd0;
      end else if (tick) begin
        dl[0] <= raw;
        for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
      end
    end
    assign tap = dl[RD_LAT-1];
  end
  always_ff @(posedge iClk_50) begin
    if (clr) begin
      oVGA_colorAddress <= 32'd0;
      oVGA_Clk <= 1'b0;
      oLineStart <= 1'b0;
      oFrameStart <= 1'b0;
      oVGA_Blank <= 1'b0;
      oVGA_HSync <= !H_SYNC_POL;
      oVGA_VSync <= !V_SYNC_POL;
      {oVGA_B, oVGA_G, oVGA_R} <= '0;
    end else begin
      oVGA_Clk <= div_nx >= DW'(CLK_DIV / 2);
      oLineStart <= tick && h_st == AV && hc == 12'd0;
      oFrameStart <= tick && act && hc == 12'd0 && vc == 12'd0;
      if (tick) begin
        oVGA_colorAddress <= act ? {4'd0, vc, 4'd0, hc} : 32'd0;
        oVGA_Blank <= tap[2];
        oVGA_HSync <= tap[1] ? H_SYNC_POL : !H_SYNC_POL;
        oVGA_VSync <= tap[0] ? V_SYNC_POL : !V_SYNC_POL;
        {oVGA_B, oVGA_G, oVGA_R} <= tap[2] ? iVGA_colorData : '0;
      end
    end
  end
endmodule
